// File: rtl/gpp_comm_buffer_if.sv
// Signal bundle between the GPP, the comm packet buffer and the photonic link.
// slave: buffer side; master: GPP/link side.
interface gpp_comm_buffer_if;
    logic        gpp_trf_dp;
    logic [15:0] gpp_tx_data;
    logic        gpp_trf_cp;
    logic        enable_rtr;
    logic        gpp_rtr_cp;
    logic [15:0] RAM_rx_data_out;
    logic        data_rx_flag;
    logic [15:0] net_tx_data;
    logic        net_tx_valid;
    logic        net_tx_last;
    logic        net_tx_ready;
    logic [15:0] net_rx_data;
    logic        net_rx_valid;
    logic        net_rx_last;

    modport slave (
        input  gpp_trf_dp, gpp_tx_data, enable_rtr, gpp_rtr_cp,
               net_tx_ready, net_rx_data, net_rx_valid, net_rx_last,
        output gpp_trf_cp, RAM_rx_data_out, data_rx_flag,
               net_tx_data, net_tx_valid, net_tx_last
    );

    modport master (
        output gpp_trf_dp, gpp_tx_data, enable_rtr, gpp_rtr_cp,
               net_tx_ready, net_rx_data, net_rx_valid, net_rx_last,
        input  gpp_trf_cp, RAM_rx_data_out, data_rx_flag,
               net_tx_data, net_tx_valid, net_tx_last
    );
endinterface

// File: rtl/gpp_comm_buffer.sv
// Packet buffer between GPP and photonic link: whole-packet TX streaming, whole-packet RX admission.
// Optional COMM_DROP_COUNT_EN adds a saturating count of discarded RX packets.
module gpp_comm_buffer #(
    parameter int unsigned PKT_WORDS = 4,
    parameter int unsigned DEPTH     = 16
) (
    input  logic              clk,
    input  logic              rst,
`ifdef COMM_DROP_COUNT_EN
    output logic [7:0]        rx_drop_count,
`endif
    gpp_comm_buffer_if.slave  bus
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned BW  = $clog2(PKT_WORDS);
    localparam int unsigned RBW = $clog2(PKT_WORDS + 2);
    localparam int unsigned NW  = $clog2(DEPTH / PKT_WORDS + 1);

    localparam logic [CW-1:0]  CNT_FULL     = CW'(DEPTH);
    localparam logic [CW-1:0]  CNT_PKT      = CW'(PKT_WORDS);
    localparam logic [CW-1:0]  RX_ADMIT_MAX = CW'(DEPTH - PKT_WORDS);
    localparam logic [BW-1:0]  BEAT_LAST    = BW'(PKT_WORDS - 1);
    localparam logic [BW-1:0]  BEAT_PENULT  = BW'(PKT_WORDS - 2);
    localparam logic [RBW-1:0] RX_PKT       = RBW'(PKT_WORDS);

    typedef enum logic       {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_ACCEPT, RX_DISCARD} rx_state_t;

    // ---------------- TX ----------------
    logic [15:0]   tx_mem [DEPTH];
    tx_state_t     tx_state, tx_state_d;
    logic [PW-1:0] tx_wr, tx_rd, tx_rd_d;
    logic [CW-1:0] tx_count, tx_count_d;
    logic [BW-1:0] tx_beat, tx_beat_d;
    logic [15:0]   tx_data_d;
    logic          tx_valid_d, tx_last_d;
    logic          tx_push, tx_pop;

    assign tx_push = bus.gpp_trf_dp && (tx_count != CNT_FULL);
    assign tx_pop  = (tx_state == TX_SEND) && bus.net_tx_ready;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= bus.gpp_tx_data;
    end

    // Next word is preloaded on each handshake so the stream has no bubbles.
    always_comb begin
        tx_state_d = tx_state;
        tx_rd_d    = tx_rd;
        tx_beat_d  = tx_beat;
        tx_data_d  = bus.net_tx_data;
        tx_valid_d = bus.net_tx_valid;
        tx_last_d  = bus.net_tx_last;
        tx_count_d = tx_count + CW'(tx_push) - CW'(tx_pop);
        case (tx_state)
            TX_IDLE: begin
                if (tx_count >= CNT_PKT) begin
                    tx_state_d = TX_SEND;
                    tx_data_d  = tx_mem[tx_rd];
                    tx_valid_d = 1'b1;
                    tx_last_d  = 1'b0;
                    tx_beat_d  = '0;
                end
            end
            TX_SEND: begin
                if (tx_pop) begin
                    tx_rd_d = tx_rd + PW'(1);
                    if (tx_beat == BEAT_LAST) begin
                        tx_state_d = TX_IDLE;
                        tx_valid_d = 1'b0;
                        tx_last_d  = 1'b0;
                        tx_beat_d  = '0;
                    end else begin
                        tx_beat_d = tx_beat + BW'(1);
                        tx_data_d = tx_mem[tx_rd + PW'(1)];
                        tx_last_d = (tx_beat == BEAT_PENULT);
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state         <= TX_IDLE;
            tx_wr            <= '0;
            tx_rd            <= '0;
            tx_count         <= '0;
            tx_beat          <= '0;
            bus.net_tx_data  <= '0;
            bus.net_tx_valid <= 1'b0;
            bus.net_tx_last  <= 1'b0;
            bus.gpp_trf_cp   <= 1'b1;
        end else begin
            tx_state         <= tx_state_d;
            tx_wr            <= tx_wr + PW'(tx_push);
            tx_rd            <= tx_rd_d;
            tx_count         <= tx_count_d;
            tx_beat          <= tx_beat_d;
            bus.net_tx_data  <= tx_data_d;
            bus.net_tx_valid <= tx_valid_d;
            bus.net_tx_last  <= tx_last_d;
            bus.gpp_trf_cp   <= (tx_count_d != CNT_FULL);
        end
    end

    // ---------------- RX ----------------
    logic [15:0]    rx_mem [DEPTH];
    rx_state_t      rx_state, rx_state_d;
    logic [PW-1:0]  rx_wr, rx_wr_d, rx_rd, pkt_start, pkt_start_d;
    logic [CW-1:0]  rx_count, rx_count_d;
    logic [NW-1:0]  pkt_count, pkt_count_d;
    logic [RBW-1:0] rx_beat, rx_beat_d, rx_new_beat;
    logic [BW-1:0]  pop_beat;
    logic           rx_we, rx_commit, rx_room, rx_err, rx_pop, pkt_dec;

    assign rx_new_beat = rx_beat + RBW'(1);
    assign rx_room     = bus.enable_rtr && (rx_count <= RX_ADMIT_MAX);
    // Length error: single-word packet, early last, or a word past PKT_WORDS.
    assign rx_err = bus.net_rx_valid &&
                    (((rx_state == RX_IDLE) && rx_room && bus.net_rx_last) ||
                     ((rx_state == RX_ACCEPT) &&
                      (bus.net_rx_last ? (rx_new_beat != RX_PKT) : (rx_new_beat > RX_PKT))));

    always_ff @(posedge clk) begin
        if (rx_we) rx_mem[rx_wr] <= bus.net_rx_data;
    end

    assign bus.RAM_rx_data_out = rx_mem[rx_rd];

    always_comb begin
        rx_state_d  = rx_state;
        rx_wr_d     = rx_wr;
        pkt_start_d = pkt_start;
        rx_beat_d   = rx_beat;
        rx_we       = 1'b0;
        rx_commit   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (bus.net_rx_valid) begin
                    if (!rx_room) begin
                        rx_state_d = bus.net_rx_last ? RX_IDLE : RX_DISCARD;
                    end else if (!rx_err) begin
                        rx_we       = 1'b1;
                        pkt_start_d = rx_wr;
                        rx_wr_d     = rx_wr + PW'(1);
                        rx_beat_d   = RBW'(1);
                        rx_state_d  = RX_ACCEPT;
                    end
                end
            end
            RX_ACCEPT: begin
                if (bus.net_rx_valid) begin
                    if (rx_err) begin
                        rx_wr_d    = pkt_start;
                        rx_state_d = bus.net_rx_last ? RX_IDLE : RX_DISCARD;
                    end else begin
                        rx_we     = 1'b1;
                        rx_wr_d   = rx_wr + PW'(1);
                        rx_beat_d = rx_new_beat;
                        if (bus.net_rx_last) begin
                            rx_commit  = 1'b1;
                            rx_state_d = RX_IDLE;
                        end
                    end
                end
            end
            RX_DISCARD: begin
                if (bus.net_rx_valid && bus.net_rx_last) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Pops only reach committed words; every PKT_WORDS-th pop retires one packet.
    assign rx_pop      = bus.gpp_rtr_cp && (pkt_count != '0);
    assign pkt_dec     = rx_pop && (pop_beat == BEAT_LAST);
    assign rx_count_d  = rx_count + (rx_commit ? CNT_PKT : '0) - CW'(rx_pop);
    assign pkt_count_d = pkt_count + NW'(rx_commit) - NW'(pkt_dec);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state         <= RX_IDLE;
            rx_wr            <= '0;
            rx_rd            <= '0;
            pkt_start        <= '0;
            rx_count         <= '0;
            pkt_count        <= '0;
            rx_beat          <= '0;
            pop_beat         <= '0;
            bus.data_rx_flag <= 1'b0;
        end else begin
            rx_state         <= rx_state_d;
            rx_wr            <= rx_wr_d;
            rx_rd            <= rx_rd + PW'(rx_pop);
            pkt_start        <= pkt_start_d;
            rx_count         <= rx_count_d;
            pkt_count        <= pkt_count_d;
            rx_beat          <= rx_beat_d;
            pop_beat         <= pkt_dec ? '0 : pop_beat + BW'(rx_pop);
            bus.data_rx_flag <= (pkt_count_d != '0);
        end
    end

`ifdef COMM_DROP_COUNT_EN
    logic rx_drop;
    assign rx_drop = rx_err || ((rx_state == RX_IDLE) && bus.net_rx_valid && !rx_room);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  rx_drop_count <= '0;
        else if (rx_drop && rx_drop_count != 8'hFF) rx_drop_count <= rx_drop_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_gpp_comm_buffer.sv
// Directed self-checking bench for gpp_comm_buffer (PKT_WORDS=4, DEPTH=16).
module tb_gpp_comm_buffer;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
`ifdef COMM_DROP_COUNT_EN
    logic [7:0] rx_drop_count;
    logic [7:0] exp_drop = 8'd0;
`endif

    gpp_comm_buffer_if bus();

    gpp_comm_buffer #(.PKT_WORDS(4), .DEPTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef COMM_DROP_COUNT_EN
        .rx_drop_count (rx_drop_count),
`endif
        .bus           (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            bus.net_rx_valid = 1'b1;
            bus.net_rx_data  = base + 16'(i);
            bus.net_rx_last  = (i == n - 1);
            tick();
        end
        bus.net_rx_valid = 1'b0;
        bus.net_rx_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.gpp_trf_dp = 1'b0; bus.gpp_tx_data = '0; bus.enable_rtr = 1'b0;
        bus.gpp_rtr_cp = 1'b0; bus.net_tx_ready = 1'b0; bus.net_rx_data = '0;
        bus.net_rx_valid = 1'b0; bus.net_rx_last = 1'b0;
        tick(); tick();
        checks++; if (bus.gpp_trf_cp !== 1'b1) begin failures++; $display("FAIL reset_cp got=%b exp=1", bus.gpp_trf_cp); end
        checks++; if (bus.data_rx_flag !== 1'b0) begin failures++; $display("FAIL reset_flag got=%b exp=0", bus.data_rx_flag); end
        checks++; if (bus.net_tx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.net_tx_valid); end
        checks++; if (bus.net_tx_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", bus.net_tx_last); end
        checks++; if (bus.net_tx_data !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", bus.net_tx_data); end
`ifdef COMM_DROP_COUNT_EN
        checks++; if (rx_drop_count !== 8'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", rx_drop_count); end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_tx_packet();
        logic [15:0] w;
        bus.net_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.gpp_trf_dp = 1'b1; bus.gpp_tx_data = 16'h1111 * 16'(i + 1);
            tick();
        end
        bus.gpp_trf_dp = 1'b0;
        checks++; if (bus.net_tx_valid !== 1'b0) begin failures++; $display("FAIL tx_valid_early got=%b exp=0", bus.net_tx_valid); end
        tick();
        for (int i = 0; i < 4; i++) begin
            w = 16'h1111 * 16'(i + 1);
            checks++; if (bus.net_tx_valid !== 1'b1) begin failures++; $display("FAIL tx_valid[%0d] got=%b exp=1", i, bus.net_tx_valid); end
            checks++; if (bus.net_tx_data !== w) begin failures++; $display("FAIL tx_data[%0d] got=%h exp=%h", i, bus.net_tx_data, w); end
            checks++; if (bus.net_tx_last !== (i == 3)) begin failures++; $display("FAIL tx_last[%0d] got=%b exp=%b", i, bus.net_tx_last, (i == 3)); end
            tick();
        end
        checks++; if (bus.net_tx_valid !== 1'b0) begin failures++; $display("FAIL tx_valid_end got=%b exp=0", bus.net_tx_valid); end
    endtask

    task automatic test_tx_partial_stall();
        logic [15:0] w;
        bus.net_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.gpp_trf_dp = 1'b1; bus.gpp_tx_data = 16'h5A01 + 16'(i);
            tick();
        end
        bus.gpp_trf_dp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.net_tx_valid !== 1'b0) begin failures++; $display("FAIL partial_valid[%0d] got=%b exp=0", i, bus.net_tx_valid); end
        end
        bus.gpp_trf_dp = 1'b1; bus.gpp_tx_data = 16'h5A04;
        tick();
        bus.gpp_trf_dp = 1'b0;
        tick();
        checks++; if (bus.net_tx_data !== 16'h5A01) begin failures++; $display("FAIL stall_first got=%h exp=5a01", bus.net_tx_data); end
        bus.net_tx_ready = 1'b1;
        tick();
        bus.net_tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (bus.net_tx_valid !== 1'b1 || bus.net_tx_data !== 16'h5A02) begin
                failures++; $display("FAIL stall_hold[%0d] got=%b/%h exp=1/5a02", i, bus.net_tx_valid, bus.net_tx_data); end
        end
        bus.net_tx_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            w = 16'h5A01 + 16'(i);
            checks++; if (bus.net_tx_data !== w || bus.net_tx_last !== (i == 3)) begin
                failures++; $display("FAIL stall_resume[%0d] got=%h/%b exp=%h/%b", i, bus.net_tx_data, bus.net_tx_last, w, (i == 3)); end
            tick();
        end
        checks++; if (bus.net_tx_valid !== 1'b0) begin failures++; $display("FAIL stall_end got=%b exp=0", bus.net_tx_valid); end
    endtask

    task automatic test_tx_full();
        logic [15:0] w;
        logic        exp_cp;
        int          t;
        bus.net_tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.gpp_trf_dp = 1'b1; bus.gpp_tx_data = 16'h0100 + 16'(i);
            tick();
            exp_cp = (i < 15);
            checks++; if (bus.gpp_trf_cp !== exp_cp) begin failures++; $display("FAIL full_cp[%0d] got=%b exp=%b", i, bus.gpp_trf_cp, exp_cp); end
        end
        bus.gpp_tx_data = 16'hDEAD;
        tick();
        bus.gpp_trf_dp = 1'b0;
        checks++; if (bus.gpp_trf_cp !== 1'b0) begin failures++; $display("FAIL full_17th_cp got=%b exp=0", bus.gpp_trf_cp); end
        bus.net_tx_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            t = 0;
            while (bus.net_tx_valid !== 1'b1 && t < 8) begin tick(); t++; end
            w = 16'h0100 + 16'(k);
            checks++; if (bus.net_tx_valid !== 1'b1) begin failures++; $display("FAIL drain_timeout[%0d] got=%b exp=1", k, bus.net_tx_valid); end
            checks++; if (bus.net_tx_data !== w || bus.net_tx_last !== ((k % 4) == 3)) begin
                failures++; $display("FAIL drain[%0d] got=%h/%b exp=%h/%b", k, bus.net_tx_data, bus.net_tx_last, w, ((k % 4) == 3)); end
            tick();
        end
        tick(); tick(); tick();
        checks++; if (bus.net_tx_valid !== 1'b0) begin failures++; $display("FAIL drain_extra got=%b exp=0", bus.net_tx_valid); end
        checks++; if (bus.gpp_trf_cp !== 1'b1) begin failures++; $display("FAIL drain_cp got=%b exp=1", bus.gpp_trf_cp); end
    endtask

    task automatic test_rx_packet();
        logic [15:0] w;
        bus.enable_rtr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.net_rx_valid = 1'b1; bus.net_rx_data = 16'h00A0 + 16'(i); bus.net_rx_last = (i == 3);
            tick();
            if (i == 2) begin
                checks++; if (bus.data_rx_flag !== 1'b0) begin failures++; $display("FAIL rx_flag_early got=%b exp=0", bus.data_rx_flag); end
            end
        end
        bus.net_rx_valid = 1'b0; bus.net_rx_last = 1'b0;
        checks++; if (bus.data_rx_flag !== 1'b1) begin failures++; $display("FAIL rx_flag got=%b exp=1", bus.data_rx_flag); end
        bus.gpp_rtr_cp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = 16'h00A0 + 16'(i);
            checks++; if (bus.RAM_rx_data_out !== w || bus.data_rx_flag !== 1'b1) begin
                failures++; $display("FAIL rx_pop[%0d] got=%h/%b exp=%h/1", i, bus.RAM_rx_data_out, bus.data_rx_flag, w); end
            tick();
        end
        bus.gpp_rtr_cp = 1'b0;
        checks++; if (bus.data_rx_flag !== 1'b0) begin failures++; $display("FAIL rx_flag_clear got=%b exp=0", bus.data_rx_flag); end
    endtask

    task automatic test_rx_length_error();
        logic [15:0] w;
        send_pkt(16'h00B0, 3);
        tick();
        checks++; if (bus.data_rx_flag !== 1'b0) begin failures++; $display("FAIL short_flag got=%b exp=0", bus.data_rx_flag); end
`ifdef COMM_DROP_COUNT_EN
        exp_drop = exp_drop + 8'd1;
        checks++; if (rx_drop_count !== exp_drop) begin failures++; $display("FAIL short_drop got=%0d exp=%0d", rx_drop_count, exp_drop); end
`endif
        send_pkt(16'h00C0, 4);
        checks++; if (bus.data_rx_flag !== 1'b1) begin failures++; $display("FAIL after_short_flag got=%b exp=1", bus.data_rx_flag); end
        bus.gpp_rtr_cp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = 16'h00C0 + 16'(i);
            checks++; if (bus.RAM_rx_data_out !== w) begin failures++; $display("FAIL after_short_pop[%0d] got=%h exp=%h", i, bus.RAM_rx_data_out, w); end
            tick();
        end
        tick(); tick();
        bus.gpp_rtr_cp = 1'b0;
        send_pkt(16'h00E0, 5);
        bus.enable_rtr = 1'b0;
        send_pkt(16'h00D0, 4);
        tick();
        checks++; if (bus.data_rx_flag !== 1'b0) begin failures++; $display("FAIL long_disabled_flag got=%b exp=0", bus.data_rx_flag); end
`ifdef COMM_DROP_COUNT_EN
        exp_drop = exp_drop + 8'd2;
        checks++; if (rx_drop_count !== exp_drop) begin failures++; $display("FAIL long_disabled_drop got=%0d exp=%0d", rx_drop_count, exp_drop); end
`endif
        bus.enable_rtr = 1'b1;
        send_pkt(16'h0070, 4);
        bus.gpp_rtr_cp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = 16'h0070 + 16'(i);
            checks++; if (bus.RAM_rx_data_out !== w) begin failures++; $display("FAIL empty_pop_pkt[%0d] got=%h exp=%h", i, bus.RAM_rx_data_out, w); end
            tick();
        end
        bus.gpp_rtr_cp = 1'b0;
    endtask

    task automatic test_rx_full_and_reset();
        logic [15:0] w;
        for (int p = 0; p < 4; p++) send_pkt(16'h1000 + 16'(p * 16), 4);
        send_pkt(16'h2000, 4);
        checks++; if (bus.data_rx_flag !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", bus.data_rx_flag); end
`ifdef COMM_DROP_COUNT_EN
        exp_drop = exp_drop + 8'd1;
        checks++; if (rx_drop_count !== exp_drop) begin failures++; $display("FAIL full_drop got=%0d exp=%0d", rx_drop_count, exp_drop); end
`endif
        bus.gpp_rtr_cp = 1'b1;
        for (int k = 0; k < 16; k++) begin
            w = 16'h1000 + 16'((k / 4) * 16) + 16'(k % 4);
            checks++; if (bus.RAM_rx_data_out !== w) begin failures++; $display("FAIL full_pop[%0d] got=%h exp=%h", k, bus.RAM_rx_data_out, w); end
            tick();
        end
        bus.gpp_rtr_cp = 1'b0;
        checks++; if (bus.data_rx_flag !== 1'b0) begin failures++; $display("FAIL full_empty_flag got=%b exp=0", bus.data_rx_flag); end

        send_pkt(16'h4000, 4);
        bus.net_tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.gpp_trf_dp = 1'b1; bus.gpp_tx_data = 16'h7771 + 16'(i);
            tick();
        end
        bus.gpp_trf_dp = 1'b0;
        tick();
        checks++; if (bus.net_tx_valid !== 1'b1 || bus.data_rx_flag !== 1'b1) begin
            failures++; $display("FAIL pre_reset got=%b/%b exp=1/1", bus.net_tx_valid, bus.data_rx_flag); end
        bus.net_rx_valid = 1'b1; bus.net_rx_data = 16'h5000; bus.net_rx_last = 1'b0;
        tick();
        bus.net_rx_data = 16'h5001;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.net_tx_valid !== 1'b0 || bus.net_tx_last !== 1'b0 || bus.net_tx_data !== 16'h0000) begin
            failures++; $display("FAIL async_rst_tx got=%b/%b/%h exp=0/0/0000", bus.net_tx_valid, bus.net_tx_last, bus.net_tx_data); end
        checks++; if (bus.data_rx_flag !== 1'b0 || bus.gpp_trf_cp !== 1'b1) begin
            failures++; $display("FAIL async_rst_rx got=%b/%b exp=0/1", bus.data_rx_flag, bus.gpp_trf_cp); end
`ifdef COMM_DROP_COUNT_EN
        checks++; if (rx_drop_count !== 8'd0) begin failures++; $display("FAIL async_rst_drop got=%0d exp=0", rx_drop_count); end
`endif
        bus.net_rx_valid = 1'b0;
        tick();
        rst = 1'b0;
        bus.net_tx_ready = 1'b1;
        tick(); tick();
        checks++; if (bus.net_tx_valid !== 1'b0) begin failures++; $display("FAIL post_rst_tx got=%b exp=0", bus.net_tx_valid); end
        send_pkt(16'h3000, 4);
        checks++; if (bus.data_rx_flag !== 1'b1 || bus.RAM_rx_data_out !== 16'h3000) begin
            failures++; $display("FAIL post_rst_rx got=%b/%h exp=1/3000", bus.data_rx_flag, bus.RAM_rx_data_out); end
    endtask

    initial begin
        test_reset();
        test_tx_packet();
        test_tx_partial_stall();
        test_tx_full();
        test_rx_packet();
        test_rx_length_error();
        test_rx_full_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
